// File: rtl/seq_detect_prog.sv
// -----------------------------------------------------------------------------
// seq_detect_prog
//
// Run-time programmable serial bit-pattern detector. One qualified bit is
// consumed per clock; the most recent len_q bits are compared against the
// programmed pattern. Supports overlapping and non-overlapping matching and
// keeps a saturating match counter. All outputs are registered.
//
// Ports:
//   clk          in   single clock, posedge
//   reset_n      in   synchronous active-low reset
//   inp_bit      in   serial data bit
//   inp_valid    in   inp_bit is consumed on this edge
//   cfg_load     in   load new configuration (wins over inp_valid)
//   cfg_pattern  in   [MAX_LEN] pattern, bit [cfg_len-1] arrives first
//   cfg_len      in   [LEN_W] pattern length, legal 1..MAX_LEN
//   cfg_overlap  in   1 = overlapping matches, 0 = non-overlapping
//   count_clr    in   clear match_count (wins over a same-cycle match)
//   seq_seen     out  one-cycle pulse per match, one cycle after the bit
//   match_count  out  [COUNT_W] saturating match count
//   cfg_err      out  one-cycle pulse when a cfg_load is rejected
// -----------------------------------------------------------------------------
module seq_detect_prog #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 LEN_W       = $clog2(MAX_LEN + 1),
    parameter int                 COUNT_W     = 16,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(8'b0000_1011),
    parameter int                 DEF_LEN     = 4,
    parameter bit                 DEF_OVERLAP = 1'b1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               inp_bit,
    input  logic               inp_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               count_clr,
    output logic               seq_seen,
    output logic [COUNT_W-1:0] match_count,
    output logic               cfg_err
);

    // Observability FSM: derived purely from fill and len.
    typedef enum logic [1:0] {
        ST_IDLE,     // fill == 0
        ST_FILLING,  // 0 < fill < len
        ST_ARMED     // fill >= len
    } state_t;

    function automatic state_t classify(input logic [LEN_W-1:0] fill,
                                        input logic [LEN_W-1:0] len);
        if (fill == '0)      return ST_IDLE;
        else if (fill < len) return ST_FILLING;
        else                 return ST_ARMED;
    endfunction

    // Configuration
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;

    // History
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    state_t             state_q, state_d;

    // Outputs
    logic               seq_seen_q, seq_seen_d;
    logic               cfg_err_q, cfg_err_d;
    logic [COUNT_W-1:0] count_q, count_d;

    // Intermediate terms
    logic               cfg_ok;
    logic               accept;
    logic               match;
    logic [LEN_W-1:0]   fill_inc;
    logic [MAX_LEN-1:0] hist_shift;
    logic [MAX_LEN-1:0] len_mask;

    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        pat_d      = pat_q;
        len_d      = len_q;
        ovl_d      = ovl_q;
        hist_d     = hist_q;
        fill_d     = fill_q;
        count_d    = count_q;
        seq_seen_d = 1'b0;
        cfg_err_d  = 1'b0;

        cfg_ok     = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
        accept     = inp_valid && !cfg_load;
        fill_inc   = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);
        hist_shift = {hist_q[MAX_LEN-2:0], inp_bit};

        // Only the low len_q bits of history and pattern take part in the compare.
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (LEN_W'(i) < len_q);
        end

        match = accept && (fill_inc >= len_q) &&
                (((hist_shift ^ pat_q) & len_mask) == '0);

        if (cfg_load) begin
            if (cfg_ok) begin
                pat_d  = cfg_pattern;
                len_d  = cfg_len;
                ovl_d  = cfg_overlap;
                hist_d = '0;
                fill_d = '0;
            end else begin
                cfg_err_d = 1'b1;
            end
        end else if (inp_valid) begin
            hist_d = hist_shift;
            // Non-overlap: restart the fill count so no bit of this match is reused.
            fill_d = (match && !ovl_q) ? '0 : fill_inc;
        end

        seq_seen_d = match;

        if (count_clr) begin
            count_d = '0;
        end else if (match && (count_q != '1)) begin
            count_d = count_q + COUNT_W'(1);
        end

        state_d = classify(fill_d, len_d);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pat_q      <= DEF_PATTERN;
            len_q      <= LEN_W'(DEF_LEN);
            ovl_q      <= DEF_OVERLAP;
            hist_q     <= '0;
            fill_q     <= '0;
            state_q    <= ST_IDLE;
            seq_seen_q <= 1'b0;
            cfg_err_q  <= 1'b0;
            count_q    <= '0;
        end else begin
            pat_q      <= pat_d;
            len_q      <= len_d;
            ovl_q      <= ovl_d;
            hist_q     <= hist_d;
            fill_q     <= fill_d;
            state_q    <= state_d;
            seq_seen_q <= seq_seen_d;
            cfg_err_q  <= cfg_err_d;
            count_q    <= count_d;
        end
    end

    // The FSM is a shadow of fill/len; keep the two views consistent.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            assert (state_q == classify(fill_q, len_q));
        end
    end

    assign seq_seen    = seq_seen_q;
    assign match_count = count_q;
    assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_seq_detect_prog.sv
// -----------------------------------------------------------------------------
// tb_seq_detect_prog
//
// Directed bench for seq_detect_prog. Two instances share all inputs: dut uses
// default parameters, dut_c is built with COUNT_W=2 for counter saturation.
// Inputs change just after the falling edge; outputs are read at the next
// falling edge, i.e. half a cycle after the rising edge that produced them.
// -----------------------------------------------------------------------------
module tb_seq_detect_prog;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;

    logic               clk;
    logic               reset_n;
    logic               inp_bit;
    logic               inp_valid;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               count_clr;

    logic               seq_seen;
    logic [15:0]        match_count;
    logic               cfg_err;
    logic               seq_seen_c;
    logic [1:0]         match_count_c;
    logic               cfg_err_c;

    int n_checks = 0;
    int n_pass   = 0;

    seq_detect_prog #(.MAX_LEN(MAX_LEN)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .inp_bit     (inp_bit),
        .inp_valid   (inp_valid),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .count_clr   (count_clr),
        .seq_seen    (seq_seen),
        .match_count (match_count),
        .cfg_err     (cfg_err)
    );

    seq_detect_prog #(.MAX_LEN(MAX_LEN), .COUNT_W(2)) dut_c (
        .clk         (clk),
        .reset_n     (reset_n),
        .inp_bit     (inp_bit),
        .inp_valid   (inp_valid),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .count_clr   (count_clr),
        .seq_seen    (seq_seen_c),
        .match_count (match_count_c),
        .cfg_err     (cfg_err_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge with the given inputs; returns at the following falling edge.
    task automatic drive(input logic b, input logic v, input logic ld,
                         input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] len,
                         input logic ovl, input logic clr);
        inp_bit     = b;
        inp_valid   = v;
        cfg_load    = ld;
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ovl;
        count_clr   = clr;
        @(posedge clk);
        @(negedge clk);
        inp_valid = 1'b0;
        cfg_load  = 1'b0;
        count_clr = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        drive(b, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic idle_cycle();
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic clear_count();
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    endtask

    // Reset edge with every other input asserted, to show reset overrides them.
    task automatic do_reset();
        reset_n = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 8'hFF, 4'd0, 1'b0, 1'b1);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (seq_seen !== 1'b0) $display("FAIL reset_seq_seen: got %b want 0", seq_seen);
        else n_pass++;
        n_checks++;
        if (match_count !== 16'd0) $display("FAIL reset_count: got %0d want 0", match_count);
        else n_pass++;
        n_checks++;
        if (cfg_err !== 1'b0) $display("FAIL reset_cfg_err: got %b want 0", cfg_err);
        else n_pass++;
        n_checks++;
        if (match_count_c !== 2'd0) $display("FAIL reset_count_c: got %0d want 0", match_count_c);
        else n_pass++;
    endtask

    task automatic test_overlap();
        logic [6:0] s = 7'b1011011;
        logic [6:0] e = 7'b0001001;
        for (int i = 6; i >= 0; i--) begin
            send_bit(s[i]);
            n_checks++;
            if (seq_seen !== e[i])
                $display("FAIL overlap_seq bit%0d: got %b want %b", 7 - i, seq_seen, e[i]);
            else n_pass++;
        end
        n_checks++;
        if (match_count !== 16'd2) $display("FAIL overlap_count: got %0d want 2", match_count);
        else n_pass++;
    endtask

    task automatic test_non_overlap();
        logic [6:0] s = 7'b1011011;
        logic [6:0] e = 7'b0001000;
        clear_count();
        drive(1'b0, 1'b0, 1'b1, 8'b0000_1011, 4'd4, 1'b0, 1'b0);
        n_checks++;
        if (cfg_err !== 1'b0) $display("FAIL nonovl_load_err: got %b want 0", cfg_err);
        else n_pass++;
        for (int i = 6; i >= 0; i--) begin
            send_bit(s[i]);
            n_checks++;
            if (seq_seen !== e[i])
                $display("FAIL nonovl_seq bit%0d: got %b want %b", 7 - i, seq_seen, e[i]);
            else n_pass++;
        end
        n_checks++;
        if (match_count !== 16'd1) $display("FAIL nonovl_count: got %0d want 1", match_count);
        else n_pass++;
    endtask

    task automatic test_reprogram_gaps();
        logic [9:0] s = 10'b1110000101;
        logic [9:0] v = 10'b1110011111;
        logic [9:0] e = 10'b0000000001;
        logic [2:0] e1 = 3'b111;
        clear_count();
        drive(1'b0, 1'b0, 1'b1, 8'b1110_0101, 4'd8, 1'b1, 1'b0);
        for (int i = 9; i >= 0; i--) begin
            drive(s[i], v[i], 1'b0, '0, '0, 1'b0, 1'b0);
            n_checks++;
            if (seq_seen !== e[i])
                $display("FAIL len8_gap_seq step%0d: got %b want %b", 10 - i, seq_seen, e[i]);
            else n_pass++;
        end
        n_checks++;
        if (match_count !== 16'd1) $display("FAIL len8_count: got %0d want 1", match_count);
        else n_pass++;
        // Length 1; bits above the length are deliberately non-zero.
        drive(1'b0, 1'b0, 1'b1, 8'b1010_1011, 4'd1, 1'b1, 1'b0);
        for (int i = 2; i >= 0; i--) begin
            send_bit(1'b1);
            n_checks++;
            if (seq_seen !== e1[i])
                $display("FAIL len1_seq bit%0d: got %b want %b", 3 - i, seq_seen, e1[i]);
            else n_pass++;
        end
        idle_cycle();
        n_checks++;
        if (seq_seen !== 1'b0) $display("FAIL len1_idle_seq: got %b want 0", seq_seen);
        else n_pass++;
    endtask

    task automatic test_cfg_reject();
        // Rejected loads carry a valid 1 that must be discarded; had it been
        // taken, the stream 0,1,1 would complete 1011 early.
        logic [6:0] s = 7'b0111011;
        logic [6:0] e = 7'b0000001;
        do_reset();
        drive(1'b1, 1'b1, 1'b1, 8'hFF, 4'd0, 1'b0, 1'b0);
        n_checks++;
        if (cfg_err !== 1'b1) $display("FAIL reject_len0_err: got %b want 1", cfg_err);
        else n_pass++;
        idle_cycle();
        n_checks++;
        if (cfg_err !== 1'b0) $display("FAIL reject_err_pulse: got %b want 0", cfg_err);
        else n_pass++;
        drive(1'b1, 1'b1, 1'b1, 8'hFF, 4'd9, 1'b0, 1'b0);
        n_checks++;
        if (cfg_err !== 1'b1) $display("FAIL reject_len9_err: got %b want 1", cfg_err);
        else n_pass++;
        for (int i = 6; i >= 0; i--) begin
            send_bit(s[i]);
            n_checks++;
            if (seq_seen !== e[i])
                $display("FAIL reject_default_seq bit%0d: got %b want %b", 7 - i, seq_seen, e[i]);
            else n_pass++;
        end
    endtask

    task automatic test_priority();
        logic [2:0] s1 = 3'b101;
        logic [2:0] s2 = 3'b011;
        for (int i = 2; i >= 0; i--) begin
            send_bit(s1[i]);
            n_checks++;
            if (seq_seen !== 1'b0)
                $display("FAIL prio_pre_seq bit%0d: got %b want 0", 3 - i, seq_seen);
            else n_pass++;
        end
        // The final 1 of 1011 arrives together with an accepted load.
        drive(1'b1, 1'b1, 1'b1, 8'b0000_1011, 4'd4, 1'b1, 1'b0);
        n_checks++;
        if (seq_seen !== 1'b0) $display("FAIL prio_load_seq: got %b want 0", seq_seen);
        else n_pass++;
        n_checks++;
        if (cfg_err !== 1'b0) $display("FAIL prio_load_err: got %b want 0", cfg_err);
        else n_pass++;
        // With history cleared, 0,1,1 cannot complete the earlier 1,0,1.
        for (int i = 2; i >= 0; i--) begin
            send_bit(s2[i]);
            n_checks++;
            if (seq_seen !== 1'b0)
                $display("FAIL prio_post_seq bit%0d: got %b want 0", 3 - i, seq_seen);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        logic [2:0] s1 = 3'b101;
        logic [3:0] s2 = 4'b1011;
        logic [3:0] e2 = 4'b0001;
        for (int i = 2; i >= 0; i--) send_bit(s1[i]);
        do_reset();
        n_checks++;
        if (match_count !== 16'd0) $display("FAIL midreset_count: got %0d want 0", match_count);
        else n_pass++;
        send_bit(1'b1);
        n_checks++;
        if (seq_seen !== 1'b0) $display("FAIL midreset_partial_seq: got %b want 0", seq_seen);
        else n_pass++;
        for (int i = 3; i >= 0; i--) begin
            send_bit(s2[i]);
            n_checks++;
            if (seq_seen !== e2[i])
                $display("FAIL midreset_seq bit%0d: got %b want %b", 4 - i, seq_seen, e2[i]);
            else n_pass++;
        end
        n_checks++;
        if (match_count !== 16'd1) $display("FAIL midreset_final_count: got %0d want 1", match_count);
        else n_pass++;
    endtask

    task automatic test_counter();
        int exp_c;
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 8'h01, 4'd1, 1'b1, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            send_bit(1'b1);
            exp_c = (i > 3) ? 3 : i;
            n_checks++;
            if (match_count_c !== 2'(exp_c))
                $display("FAIL sat_count match%0d: got %0d want %0d", i, match_count_c, exp_c);
            else n_pass++;
        end
        n_checks++;
        if (match_count !== 16'd5) $display("FAIL wide_count: got %0d want 5", match_count);
        else n_pass++;
        // Clear coincident with a match: clear wins, but the match still pulses.
        drive(1'b1, 1'b1, 1'b0, '0, '0, 1'b0, 1'b1);
        n_checks++;
        if (match_count_c !== 2'd0) $display("FAIL clr_vs_match_count: got %0d want 0", match_count_c);
        else n_pass++;
        n_checks++;
        if (seq_seen !== 1'b1) $display("FAIL clr_vs_match_seq: got %b want 1", seq_seen);
        else n_pass++;
        send_bit(1'b1);
        n_checks++;
        if (match_count_c !== 2'd1) $display("FAIL after_clr_count: got %0d want 1", match_count_c);
        else n_pass++;
    endtask

    initial begin
        reset_n     = 1'b0;
        inp_bit     = 1'b0;
        inp_valid   = 1'b0;
        cfg_load    = 1'b0;
        cfg_pattern = '0;
        cfg_len     = '0;
        cfg_overlap = 1'b0;
        count_clr   = 1'b0;
        @(negedge clk);

        test_reset();
        test_overlap();
        test_non_overlap();
        test_reprogram_gaps();
        test_cfg_reject();
        test_priority();
        test_reset_mid();
        test_counter();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
